// File: rtl/line_pixel_walker.sv
// Walks the Bresenham line between two ROM-resolved pins and emits one pixel per handshake.
// Optional feature macro: STRING_LINE_OMIT_END_EN (drop the end pixel so chained strings share pins once).
module line_pixel_walker #(
  parameter int unsigned PIN_W   = 8,
  parameter int unsigned COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [PIN_W-1:0]   pin_1_index,
  input  logic [PIN_W-1:0]   pin_2_index,
  input  logic               add_or_remove,
  output logic [PIN_W-1:0]   pin_addr,
  input  logic [COORD_W-1:0] pin_x,
  input  logic [COORD_W-1:0] pin_y,
  output logic               pix_val,
  input  logic               pix_rdy,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_add,
  output logic               line_done,
  output logic               busy
);

  localparam int unsigned SW = COORD_W + 2;
  localparam logic signed [SW-1:0] ZERO = '0;

  typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, SETUP, DRAW, DONE} state_t;

  state_t                state;
  logic [PIN_W-1:0]      p2_idx;
  logic [COORD_W-1:0]    x1, y1, x2, y2;
  logic signed [SW-1:0]  dx, dy, err;
  logic                  sx_neg, sy_neg;

  logic signed [SW-1:0]  diff_x_c, diff_y_c, abs_x_c, abs_y_c, e2_c, err_nxt_c;
  logic                  step_x_c, step_y_c, at_end_c, next_end_c, finish_c, same_c;
  logic [COORD_W-1:0]    x_nxt_c, y_nxt_c;

  // Setup deltas from the captured start point and the end point on the ROM bus
  always_comb begin
    diff_x_c = $signed({2'b00, pin_x}) - $signed({2'b00, x1});
    diff_y_c = $signed({2'b00, pin_y}) - $signed({2'b00, y1});
    abs_x_c  = (diff_x_c < ZERO) ? -diff_x_c : diff_x_c;
    abs_y_c  = (diff_y_c < ZERO) ? -diff_y_c : diff_y_c;
    same_c   = (pin_x == x1) && (pin_y == y1);
  end

  // One Bresenham step; both rules use the same e2
  always_comb begin
    e2_c      = err <<< 1;
    step_x_c  = (e2_c >= dy);
    step_y_c  = (e2_c <= dx);
    err_nxt_c = err + (step_x_c ? dy : ZERO) + (step_y_c ? dx : ZERO);
    x_nxt_c   = pix_x;
    y_nxt_c   = pix_y;
    if (step_x_c) x_nxt_c = sx_neg ? pix_x - COORD_W'(1) : pix_x + COORD_W'(1);
    if (step_y_c) y_nxt_c = sy_neg ? pix_y - COORD_W'(1) : pix_y + COORD_W'(1);
    at_end_c   = (pix_x == x2) && (pix_y == y2);
    next_end_c = (x_nxt_c == x2) && (y_nxt_c == y2);
`ifdef STRING_LINE_OMIT_END_EN
    finish_c = next_end_c;
`else
    finish_c = at_end_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_rdy   <= 1'b1;
      busy      <= 1'b0;
      pin_addr  <= '0;
      p2_idx    <= '0;
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      pix_val   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_add   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            pin_addr <= pin_1_index;
            p2_idx   <= pin_2_index;
            pix_add  <= add_or_remove;
            req_rdy  <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH1;
          end
        end
        FETCH1: begin
          pin_addr <= p2_idx;
          state    <= FETCH2;
        end
        FETCH2: begin
          x1    <= pin_x;
          y1    <= pin_y;
          state <= SETUP;
        end
        SETUP: begin
          x2     <= pin_x;
          y2     <= pin_y;
          pix_x  <= x1;
          pix_y  <= y1;
          dx     <= abs_x_c;
          dy     <= -abs_y_c;
          err    <= abs_x_c - abs_y_c;
          sx_neg <= !(x1 < pin_x);
          sy_neg <= !(y1 < pin_y);
`ifdef STRING_LINE_OMIT_END_EN
          if (same_c) begin
            line_done <= 1'b1;
            state     <= DONE;
          end else begin
            pix_val <= 1'b1;
            state   <= DRAW;
          end
`else
          pix_val <= 1'b1;
          state   <= DRAW;
`endif
        end
        DRAW: begin
          if (pix_val && pix_rdy) begin
            if (finish_c) begin
              pix_val   <= 1'b0;
              line_done <= 1'b1;
              state     <= DONE;
            end else begin
              pix_x <= x_nxt_c;
              pix_y <= y_nxt_c;
              err   <= err_nxt_c;
            end
          end
        end
        DONE: begin
          line_done <= 1'b0;
          req_rdy   <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // same_c only steers SETUP when the end pixel is omitted; at_end_c/next_end_c feed finish_c
  logic unused_c;
  assign unused_c = same_c ^ at_end_c ^ next_end_c;

endmodule

// File: tb/tb_line_pixel_walker.sv
// Directed bench for line_pixel_walker: hand-computed Bresenham lines, backpressure, reset abort.
module tb_line_pixel_walker;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] pin_1_index, pin_2_index;
  logic       add_or_remove;
  logic [7:0] pin_addr;
  logic [9:0] pin_x, pin_y;
  logic       pix_val, pix_rdy;
  logic [9:0] pix_x, pix_y;
  logic       pix_add, line_done, busy;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];

  line_pixel_walker dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .pin_1_index(pin_1_index), .pin_2_index(pin_2_index), .add_or_remove(add_or_remove),
    .pin_addr(pin_addr), .pin_x(pin_x), .pin_y(pin_y),
    .pix_val(pix_val), .pix_rdy(pix_rdy), .pix_x(pix_x), .pix_y(pix_y),
    .pix_add(pix_add), .line_done(line_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous pin ROM: pin 0 (0,0), 1 (4,0), 2 (1,3), 3 (5,5), 4 (2,2), 5 (3,7)
  always @(posedge clk) begin
    case (pin_addr)
      8'd1:    begin pin_x <= 10'd4; pin_y <= 10'd0; end
      8'd2:    begin pin_x <= 10'd1; pin_y <= 10'd3; end
      8'd3:    begin pin_x <= 10'd5; pin_y <= 10'd5; end
      8'd4:    begin pin_x <= 10'd2; pin_y <= 10'd2; end
      8'd5:    begin pin_x <= 10'd3; pin_y <= 10'd7; end
      default: begin pin_x <= 10'd0; pin_y <= 10'd0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pt(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  // Expected pixels are in exp_q; toggle=1 alternates pix_rdy
  task automatic run_line(input logic [7:0] p1, input logic [7:0] p2, input logic add,
                          input bit toggle);
    int n = 0;
    int cyc;
    int first_cyc = -1;
    int done_cyc = -1;
    int n_exp;
    bit held = 0;
    logic [19:0] hxy;
`ifdef STRING_LINE_OMIT_END_EN
    void'(exp_q.pop_back());
`endif
    n_exp = exp_q.size();
    @(negedge clk);
    check("req_rdy_idle", 32'(req_rdy), 32'd1);
    req_val = 1'b1; pin_1_index = p1; pin_2_index = p2; add_or_remove = add;
    @(negedge clk);
    req_val = 1'b0;
    cyc = 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("req_rdy_after_accept", 32'(req_rdy), 32'd0);
    while (done_cyc < 0 && cyc < 200) begin
      pix_rdy = toggle ? cyc[0] : 1'b1;
      if (held) begin
        check("hold_xy", 32'({pix_x, pix_y}), 32'(hxy));
        check("hold_val", 32'(pix_val), 32'd1);
      end
      held = 0;
      if (pix_val) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pix_rdy) begin
          if (n < n_exp) check("pixel_xy", 32'({pix_x, pix_y}), 32'(exp_q[n]));
          else check("extra_pixel", 32'(n), 32'(n_exp));
          check("pix_add", 32'(pix_add), 32'(add));
          n++;
        end else begin
          held = 1;
          hxy = {pix_x, pix_y};
        end
      end
      if (line_done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("line_done_seen", 32'(done_cyc >= 0), 32'd1);
    check("pixel_count", 32'(n), 32'(n_exp));
    if (!toggle) begin
      check("done_latency", 32'(done_cyc), 32'(4 + n_exp));
      if (n_exp > 0) check("first_pix_latency", 32'(first_cyc), 32'd4);
    end
    @(negedge clk);
    pix_rdy = 1'b1;
    check("line_done_pulse", 32'(line_done), 32'd0);
    check("req_rdy_back", 32'(req_rdy), 32'd1);
    check("busy_back", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; req_val = 1'b0; pin_1_index = '0; pin_2_index = '0;
    add_or_remove = 1'b0; pix_rdy = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_pix_val", 32'(pix_val), 32'd0);
    check("rst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rst_pix_add", 32'(pix_add), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pin_addr", 32'(pin_addr), 32'd0);

    exp_q = '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(4,0)};
    run_line(8'd0, 8'd1, 1'b1, 1'b0);
    exp_q = '{pt(0,0), pt(0,1), pt(1,2), pt(1,3)};
    run_line(8'd0, 8'd2, 1'b1, 1'b0);
    exp_q = '{pt(1,3), pt(1,2), pt(0,1), pt(0,0)};
    run_line(8'd2, 8'd0, 1'b1, 1'b0);
    exp_q = '{pt(5,5), pt(4,4), pt(3,3), pt(2,2)};
    run_line(8'd3, 8'd4, 1'b0, 1'b0);
    exp_q = '{pt(0,0), pt(0,1), pt(1,2), pt(1,3)};
    run_line(8'd0, 8'd2, 1'b0, 1'b1);
    exp_q = '{pt(5,5), pt(4,4), pt(3,3), pt(2,2)};
    run_line(8'd3, 8'd4, 1'b1, 1'b1);
    exp_q = '{pt(3,7)};
    run_line(8'd5, 8'd5, 1'b1, 1'b0);

    // Abort the horizontal line after its second pixel
    @(negedge clk);
    req_val = 1'b1; pin_1_index = 8'd0; pin_2_index = 8'd1; add_or_remove = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_second_pix", 32'({pix_x, pix_y}), 32'(pt(1,0)));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pix_val", 32'(pix_val), 32'd0);
    check("abort_req_rdy", 32'(req_rdy), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pix_xy", 32'({pix_x, pix_y}), 32'd0);
    saw_done = line_done;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | line_done;
    end
    check("abort_no_line_done", 32'(saw_done), 32'd0);
    exp_q = '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(4,0)};
    run_line(8'd0, 8'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
